// File: rtl/digit_serial_adder_pkg.sv
// Shared constants, FSM encoding and sizing helper for the digit-serial adder.
// No logic of its own; imported by the slice and the top.
package adder_pkg;

    localparam int DIGIT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width; a one-digit operation still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle: operands in over valid/ready, result out over valid/ready.
// master drives operands and out_ready; slave is the adder side.
interface digit_serial_adder_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/digit_serial_adder_add3_slice.sv
// Combinational W-bit ripple-carry adder slice; zero latency, no state, no handshake.
module add3_slice
    import adder_pkg::*;
#(
    parameter int W = DIGIT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic c;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: one DIGIT-bit slice per cycle, LSD first; result valid N edges after accept.
// Single operation in flight: in_ready only in IDLE; result held in DONE until out_ready.
module digit_serial_adder #(
    parameter int WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    digit_serial_adder_if.slave  bus
);
    import adder_pkg::*;

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    // The result shift register splits at DIGIT, so at least two digits are needed.
    if ((WIDTH % DIGIT) != 0 || N < 2) begin : g_bad_width
        $error("digit_serial_adder: WIDTH must be a multiple of DIGIT and hold at least two digits");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, res_q;
    logic              carry_q;
    logic [CW-1:0]     cnt_q;
    logic [DIGIT-1:0]  sum_dig;
    logic              cout_dig;
    logic              in_ready;
    logic              out_valid;
    logic              accept;

    add3_slice #(.W(DIGIT)) u_slice (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (sum_dig),
        .cout (cout_dig)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)                  state_d = RUN;
            RUN:     if (cnt_q == CW'(N - 1))     state_d = DONE;
            DONE:    if (bus.out_ready)           state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = res_q;
    assign bus.out_cout  = carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    a_q     <= bus.in_a;
                    b_q     <= bus.in_b;
                    carry_q <= bus.in_cin;
                    cnt_q   <= '0;
                end
                RUN: begin
                    // Sum digits enter at the top, so after N shifts digit 0 sits at bit 0.
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    res_q   <= {sum_dig, res_q[WIDTH-1:DIGIT]};
                    carry_q <= cout_dig;
                    if (cnt_q != CW'(N - 1)) cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Randomized self-checking bench for digit_serial_adder against an a+b+cin reference.
module tb_digit_serial_adder;

    localparam int W = 12;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    logic [W-1:0] seen1, seen0;

    digit_serial_adder_if #(.WIDTH(W)) bus ();

    digit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    // One full operation: accept, latency check, optional hold with out_ready low, drain.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int pre, input int hold);
        logic [W:0] exp;
        int         lat;
        exp = ref_add(a, b, cin);
        repeat (pre) @(negedge clk);
        lat = 0;
        while (!bus.in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.out_ready = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            // Operands are ignored after acceptance; scramble them and out_ready.
            bus.in_valid  = 1'($urandom);
            bus.in_a      = W'($urandom);
            bus.in_b      = W'($urandom);
            bus.in_cin    = 1'($urandom);
            bus.out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        bus.out_ready = 1'b0;
        chk("latency", 32'(lat), 32'd4);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_sum", 32'(bus.out_sum), 32'(exp[W-1:0]));
            chk("hold_cout", 32'(bus.out_cout), 32'(exp[W]));
            @(negedge clk);
        end
        chk("sum", 32'(bus.out_sum), 32'(exp[W-1:0]));
        chk("cout", 32'(bus.out_cout), 32'(exp[W]));
        chk("done_in_ready", 32'(bus.in_ready), 32'd0);
        seen1 = seen1 | bus.out_sum;
        seen0 = seen0 | ~bus.out_sum;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("valid_drop", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [W:0] q[$];
        logic [W:0] e;
        logic [W-1:0] ta[3];
        logic [W-1:0] tb[3];
        logic         tc[3];
        int nacc, nres, cyc, last_acc;
        bit load_next;

        n_chk = 0;
        n_pass = 0;
        seen1 = '0;
        seen0 = '0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_cin = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_out_cout", 32'(bus.out_cout), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed operations, including full carry ripple and backpressure
        run_op(12'hFFF, 12'h001, 1'b0, 0, 0);
        run_op(12'h5A5, 12'h25A, 1'b1, 0, 0);
        run_op(12'h000, 12'h000, 1'b0, 0, 0);
        run_op(12'hABC, 12'h987, 1'b1, 0, 5);

        // Reset in the middle of RUN after two digits
        while (!bus.in_ready) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a = 12'hFFF;
        bus.in_b = 12'hFFF;
        bus.in_cin = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_sum", 32'(bus.out_sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("postrst_no_valid", 32'(bus.out_valid), 32'd0);
        end
        run_op(12'h123, 12'h456, 1'b0, 0, 0);

        // Back-to-back with in_valid and out_ready tied high
        ta[0] = 12'h7FF; tb[0] = 12'h801; tc[0] = 1'b0;
        ta[1] = 12'h0F0; tb[1] = 12'h00F; tc[1] = 1'b1;
        ta[2] = 12'hC3C; tb[2] = 12'h5A5; tc[2] = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a = ta[0];
        bus.in_b = tb[0];
        bus.in_cin = tc[0];
        nacc = 0;
        nres = 0;
        cyc = 0;
        last_acc = 0;
        load_next = 1'b0;
        while (nres < 3 && cyc < 40) begin
            if (load_next) begin
                load_next = 1'b0;
                if (nacc < 3) begin
                    bus.in_a = ta[nacc];
                    bus.in_b = tb[nacc];
                    bus.in_cin = tc[nacc];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            chk("b2b_excl", 32'(bus.in_ready && bus.out_valid), 32'd0);
            if (bus.out_valid) begin
                e = q.pop_front();
                chk("b2b_sum", 32'(bus.out_sum), 32'(e[W-1:0]));
                chk("b2b_cout", 32'(bus.out_cout), 32'(e[W]));
                nres++;
            end
            if (bus.in_ready && bus.in_valid) begin
                if (nacc > 0) chk("b2b_period", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                q.push_back(ref_add(bus.in_a, bus.in_b, bus.in_cin));
                nacc++;
                load_next = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        chk("b2b_results", 32'(nres), 32'd3);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized operations with input stalls and output backpressure
        for (int n = 0; n < 1500; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)));
        end
        chk("sum_toggle_hi", 32'(seen1), 32'(12'hFFF));
        chk("sum_toggle_lo", 32'(seen0), 32'(12'hFFF));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
